// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the 64-bit RV core: walks each instruction through
// fetch/decode/execute/mem/writeback and drives datapath strobes over one shared memory port.
module multicycle_ctrl_fsm #(
   parameter int MEM_TIMEOUT  = 16,
   parameter bit ILLEGAL_HALT = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_addr_sel,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [2:0] imm_type,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic [3:0] state,
   output logic       halted,
   output logic       timeout_err
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      ADDR   = 4'd2,
      MEM_RD = 4'd3,
      MEM_WR = 4'd4,
      WB_MEM = 4'd5,
      EXEC_I = 4'd6,
      EXEC_R = 4'd7,
      WB_ALU = 4'd8,
      BRANCH = 4'd9,
      UPPER  = 4'd10,
      JUMP   = 4'd11,
      HALT   = 4'd15
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [2:0] imm_q, imm_d;
   logic       is_store_q, is_store_d;
   logic [7:0] wait_q, wait_d;
   logic       terr_q, terr_d;
   logic       mem_phase, timeout_hit;

   logic       req_c, we_c, addr_sel_c, ir_write_c, pc_write_c, reg_write_c;
   logic [1:0] pc_src_c, alu_src_b_c, alu_op_c, wb_sel_c;

   // The wait counter only advances while the port is requested and not yet served.
   assign mem_phase   = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
   assign timeout_hit = (MEM_TIMEOUT != 0) && mem_phase && !mem_ready && (wait_q == WAIT_LAST);

   always_comb begin
      state_d     = state_q;
      imm_d       = imm_q;
      is_store_d  = is_store_q;
      req_c       = 1'b0;
      we_c        = 1'b0;
      addr_sel_c  = 1'b0;
      ir_write_c  = 1'b0;
      pc_write_c  = 1'b0;
      reg_write_c = 1'b0;
      pc_src_c    = 2'b00;
      alu_src_b_c = 2'b00;
      alu_op_c    = 2'b00;
      wb_sel_c    = 2'b00;

      case (state_q)
         FETCH: begin
            req_c = 1'b1;
            if (mem_ready) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
               state_d    = DECODE;
            end else if (timeout_hit) begin
               state_d = HALT;
            end
         end
         DECODE: begin
            is_store_d = 1'b0;
            case (opcode)
               7'b0000011: begin imm_d = 3'b000; state_d = ADDR; end
               7'b0100011: begin imm_d = 3'b001; is_store_d = 1'b1; state_d = ADDR; end
               7'b0010011: begin imm_d = 3'b000; state_d = EXEC_I; end
               7'b0110011: begin imm_d = 3'b000; state_d = EXEC_R; end
               7'b1100011: begin imm_d = 3'b010; state_d = BRANCH; end
               7'b0110111: begin imm_d = 3'b011; state_d = UPPER; end
               7'b1101111: begin imm_d = 3'b100; state_d = JUMP; end
               default: begin
                  imm_d   = 3'b000;
                  state_d = ILLEGAL_HALT ? HALT : FETCH;
               end
            endcase
         end
         ADDR: begin
            alu_src_b_c = 2'b01;
            state_d     = is_store_q ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            req_c      = 1'b1;
            addr_sel_c = 1'b1;
            if (mem_ready)        state_d = WB_MEM;
            else if (timeout_hit) state_d = HALT;
         end
         MEM_WR: begin
            req_c      = 1'b1;
            we_c       = 1'b1;
            addr_sel_c = 1'b1;
            if (mem_ready)        state_d = FETCH;
            else if (timeout_hit) state_d = HALT;
         end
         WB_MEM: begin
            reg_write_c = 1'b1;
            wb_sel_c    = 2'b01;
            state_d     = FETCH;
         end
         EXEC_I: begin
            alu_src_b_c = 2'b01;
            alu_op_c    = 2'b10;
            state_d     = WB_ALU;
         end
         EXEC_R: begin
            alu_op_c = 2'b10;
            state_d  = WB_ALU;
         end
         WB_ALU: begin
            reg_write_c = 1'b1;
            state_d     = FETCH;
         end
         BRANCH: begin
            alu_op_c   = 2'b01;
            pc_src_c   = 2'b01;
            pc_write_c = zero;
            state_d    = FETCH;
         end
         UPPER: begin
            reg_write_c = 1'b1;
            wb_sel_c    = 2'b11;
            state_d     = FETCH;
         end
         JUMP: begin
            reg_write_c = 1'b1;
            wb_sel_c    = 2'b10;
            pc_write_c  = 1'b1;
            pc_src_c    = 2'b10;
            state_d     = FETCH;
         end
         HALT:    state_d = HALT;
         default: state_d = HALT;
      endcase

      terr_d = terr_q | timeout_hit;

      // Any state change lands on a fresh access (or leaves the memory phase), so restart the count.
      if (mem_ready || (state_d != state_q)) wait_d = 8'd0;
      else if (mem_phase)                    wait_d = wait_q + 8'd1;
      else                                   wait_d = wait_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= FETCH;
         imm_q      <= 3'b000;
         is_store_q <= 1'b0;
         wait_q     <= 8'd0;
         terr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         imm_q      <= imm_d;
         is_store_q <= is_store_d;
         wait_q     <= wait_d;
         terr_q     <= terr_d;
      end
   end

   // Outputs are forced low while reset is asserted so an in-flight access drops immediately.
   assign mem_req      = rst_n & req_c;
   assign mem_we       = rst_n & we_c;
   assign mem_addr_sel = rst_n & addr_sel_c;
   assign ir_write     = rst_n & ir_write_c;
   assign pc_write     = rst_n & pc_write_c;
   assign reg_write    = rst_n & reg_write_c;
   assign pc_src       = rst_n ? pc_src_c    : 2'b00;
   assign alu_src_b    = rst_n ? alu_src_b_c : 2'b00;
   assign alu_op       = rst_n ? alu_op_c    : 2'b00;
   assign wb_sel       = rst_n ? wb_sel_c    : 2'b00;
   assign imm_type     = rst_n ? imm_q       : 3'b000;
   assign state        = rst_n ? 4'(state_q) : 4'd0;
   assign halted       = rst_n & (state_q == HALT);
   assign timeout_err  = rst_n & terr_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle strobe/select/state checks against
// hand-derived values for each instruction class, reset, halt and memory timeout.
module tb_multicycle_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rst_n, zero, mem_ready;
   logic [6:0] opcode;
   logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write, halted, timeout_err;
   logic [1:0] pc_src, alu_src_b, alu_op, wb_sel;
   logic [2:0] imm_type;
   logic [3:0] state;

   int n_chk  = 0;
   int n_pass = 0;

   multicycle_ctrl_fsm #(.MEM_TIMEOUT(16), .ILLEGAL_HALT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .imm_type(imm_type), .reg_write(reg_write), .wb_sel(wb_sel), .state(state),
      .halted(halted), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", tag, got, exp);
   endtask

   // strb = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write, halted, timeout_err}
   // sel  = {pc_src, alu_src_b, alu_op, wb_sel}
   task automatic chk_cyc(input string tag, input logic [7:0] strb, input logic [7:0] sel,
                          input logic [7:0] st);
      chk({tag, ".strb"}, {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write,
                           halted, timeout_err}, strb);
      chk({tag, ".sel"}, {pc_src, alu_src_b, alu_op, wb_sel}, sel);
      chk({tag, ".state"}, 8'(state), st);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_fetch(input string tag);
      mem_ready = 1'b1;
      #1;
      chk_cyc({tag, ".fetch"}, 8'b1001_1000, 8'h00, 8'd0);
      tick();
   endtask

   task automatic do_decode(input string tag, input logic [6:0] op);
      opcode = op;
      #1;
      chk_cyc({tag, ".decode"}, 8'h00, 8'h00, 8'd1);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; zero = 1'b0; mem_ready = 1'b1; opcode = 7'b0000000;
      @(posedge clk); #1;
      tick(); tick();
      chk_cyc("rst", 8'h00, 8'h00, 8'd0);
      chk("rst.imm", 8'(imm_type), 8'd0);

      // release with zero-wait fetch, then addi
      rst_n = 1'b1;
      do_fetch("addi");
      do_decode("addi", 7'b0010011);
      opcode = 7'b1111111;
      #1;
      chk_cyc("addi.exec", 8'h00, 8'b00_01_10_00, 8'd6);
      chk("addi.imm", 8'(imm_type), 8'd0);
      tick();
      #1;
      chk_cyc("addi.wb", 8'b0000_0100, 8'h00, 8'd8);
      tick();

      // lw with three wait cycles; opcode change after DECODE must not matter
      do_fetch("lw");
      do_decode("lw", 7'b0000011);
      opcode = 7'b0100011;
      #1;
      chk_cyc("lw.addr", 8'h00, 8'b00_01_00_00, 8'd2);
      tick();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk_cyc("lw.wait", 8'b1010_0000, 8'h00, 8'd3);
         tick();
      end
      mem_ready = 1'b1;
      #1;
      chk_cyc("lw.rd", 8'b1010_0000, 8'h00, 8'd3);
      tick();
      #1;
      chk_cyc("lw.wb", 8'b0000_0100, 8'b00_00_00_01, 8'd5);
      tick();
      #1;
      chk("lw.back", 8'(state), 8'd0);

      // sw zero-wait
      do_fetch("sw");
      do_decode("sw", 7'b0100011);
      #1;
      chk_cyc("sw.addr", 8'h00, 8'b00_01_00_00, 8'd2);
      chk("sw.imm", 8'(imm_type), 8'd1);
      tick();
      #1;
      chk_cyc("sw.wr", 8'b1110_0000, 8'h00, 8'd4);
      tick();

      // R-type
      do_fetch("r");
      do_decode("r", 7'b0110011);
      #1;
      chk_cyc("r.exec", 8'h00, 8'b00_00_10_00, 8'd7);
      tick();
      #1;
      chk_cyc("r.wb", 8'b0000_0100, 8'h00, 8'd8);
      tick();

      // beq taken, then not taken with zero toggled combinationally
      do_fetch("beq1");
      do_decode("beq1", 7'b1100011);
      zero = 1'b1;
      #1;
      chk_cyc("beq1.br", 8'b0000_1000, 8'b01_00_01_00, 8'd9);
      chk("beq.imm", 8'(imm_type), 8'd2);
      tick();
      do_fetch("beq0");
      do_decode("beq0", 7'b1100011);
      zero = 1'b0;
      #1;
      chk_cyc("beq0.br", 8'h00, 8'b01_00_01_00, 8'd9);
      zero = 1'b1;
      #1;
      chk("beq0.comb", 8'(pc_write), 8'd1);
      zero = 1'b0;
      tick();

      // jal and lui
      do_fetch("jal");
      do_decode("jal", 7'b1101111);
      #1;
      chk_cyc("jal.jump", 8'b0000_1100, 8'b10_00_00_10, 8'd11);
      chk("jal.imm", 8'(imm_type), 8'd4);
      tick();
      do_fetch("lui");
      do_decode("lui", 7'b0110111);
      #1;
      chk_cyc("lui.upper", 8'b0000_0100, 8'b00_00_00_11, 8'd10);
      chk("lui.imm", 8'(imm_type), 8'd3);
      tick();

      // ready arriving on the last allowed wait cycle wins over the timeout
      mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      #1;
      chk("tw.pre", 8'(state), 8'd0);
      do_fetch("tw");
      chk("tw.err", 8'(timeout_err), 8'd0);
      do_decode("tw", 7'b0000011);
      tick();
      // reset mid-access drops mem_req in the same cycle
      mem_ready = 1'b0;
      #1;
      chk_cyc("mid.rd", 8'b1010_0000, 8'h00, 8'd3);
      rst_n = 1'b0;
      #1;
      chk_cyc("mid.rst", 8'h00, 8'h00, 8'd0);
      tick();
      rst_n = 1'b1;

      // illegal opcode halts; halt ignores memory and opcode activity
      do_fetch("ill");
      do_decode("ill", 7'b1111111);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk_cyc("ill.halt", 8'b0000_0010, 8'h00, 8'd15);
         tick();
      end
      rst_n = 1'b0;
      #1;
      chk("ill.rst", 8'(halted), 8'd0);
      tick();

      // fetch never served: error after 16 waiting cycles, then halt
      rst_n = 1'b1;
      mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      #1;
      chk_cyc("to.last", 8'b1000_0000, 8'h00, 8'd0);
      tick();
      #1;
      chk_cyc("to.halt", 8'b0000_0011, 8'h00, 8'd15);
      tick();
      #1;
      chk_cyc("to.sticky", 8'b0000_0011, 8'h00, 8'd15);
      rst_n = 1'b0;
      #1;
      chk_cyc("to.rst", 8'h00, 8'h00, 8'd0);
      tick();
      rst_n = 1'b1;
      #1;
      chk_cyc("to.clr", 8'b1000_0000, 8'h00, 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
